// File: rtl/neighborhood_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : neighborhood_window_gen
// Brief    : Streaming zero-padded 3x3 window generator with two RAM line
//            buffers, emitting one window per raster pixel plus coordinates.
// Revision : 1.0 - initial release
// ============================================================================
module neighborhood_window_gen #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int PIXEL_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PIXEL_WIDTH-1:0]    in_pixel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [9*PIXEL_WIDTH-1:0]  out_window,
    output logic [$clog2(WIDTH)-1:0]  out_x,
    output logic [$clog2(HEIGHT)-1:0] out_y,
    output logic                      out_last
);

    localparam int c_XW = $clog2(WIDTH);
    localparam int c_YW = $clog2(HEIGHT);
    localparam int c_IW = $clog2(WIDTH * HEIGHT);

    localparam logic [c_XW-1:0] c_X_MAX    = c_XW'(WIDTH - 1);
    localparam logic [c_YW-1:0] c_Y_MAX    = c_YW'(HEIGHT - 1);
    localparam logic [c_IW-1:0] c_IDX_FILL = c_IW'(WIDTH);
    localparam logic [c_IW-1:0] c_IDX_MAX  = c_IW'(WIDTH * HEIGHT - 1);

    localparam logic [1:0] c_S_FILL  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_FLUSH = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [c_IW-1:0]        r_idx;
    logic [c_XW-1:0]        r_col;
    logic [c_XW-1:0]        r_nx;
    logic [c_YW-1:0]        r_ny;

    logic [PIXEL_WIDTH-1:0] r_lb0 [WIDTH];
    logic [PIXEL_WIDTH-1:0] r_lb1 [WIDTH];
    logic [PIXEL_WIDTH-1:0] r_win    [3][3];
    logic [PIXEL_WIDTH-1:0] w_win_nx [3][3];

    logic                     w_flush_step;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic                     w_shift;
    logic                     w_produce;
    logic [PIXEL_WIDTH-1:0]   w_shift_px;
    logic [PIXEL_WIDTH-1:0]   w_lb0_rd;
    logic [PIXEL_WIDTH-1:0]   w_lb1_rd;
    logic [9*PIXEL_WIDTH-1:0] w_window_masked;
    logic                     w_left;
    logic                     w_right;
    logic                     w_top;
    logic                     w_bottom;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_FILL:  if (w_in_fire && r_idx == c_IDX_FILL) w_state_next = c_S_RUN;
            c_S_RUN:   if (w_in_fire && r_idx == c_IDX_MAX)  w_state_next = c_S_FLUSH;
            c_S_FLUSH: if (w_out_fire && out_last)           w_state_next = c_S_FILL;
            default:   w_state_next = c_S_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Flushing stops once the final window is parked.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready     = 1'b0;
        w_flush_step = 1'b0;
        case (r_state)
            c_S_FILL:  in_ready     = !rst;
            c_S_RUN:   in_ready     = !rst && (!out_valid || out_ready);
            c_S_FLUSH: w_flush_step = (!out_valid || out_ready) && !(out_valid && out_last);
            default:   ;
        endcase
    end

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_shift    = w_in_fire || w_flush_step;
    assign w_produce  = (r_state == c_S_RUN && w_in_fire) || w_flush_step;
    assign w_shift_px = w_flush_step ? '0 : in_pixel;

    assign w_lb0_rd = r_lb0[r_col];
    assign w_lb1_rd = r_lb1[r_col];

    // Read-before-write: lb1 holds the previous row, lb0 the one before it.
    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_lb1[r_col] <= w_shift_px;
            r_lb0[r_col] <= w_lb1_rd;
        end
    end

    always_comb begin
        for (int ri = 0; ri < 3; ri++) begin
            w_win_nx[ri][0] = r_win[ri][1];
            w_win_nx[ri][1] = r_win[ri][2];
        end
        w_win_nx[0][2] = w_lb0_rd;
        w_win_nx[1][2] = w_lb1_rd;
        w_win_nx[2][2] = w_shift_px;
    end

    assign w_left   = (r_nx == '0);
    assign w_right  = (r_nx == c_X_MAX);
    assign w_top    = (r_ny == '0);
    assign w_bottom = (r_ny == c_Y_MAX);

    // Masking by coordinate hides stale line-buffer data and row wrap.
    always_comb begin
        w_window_masked = '0;
        for (int ri = 0; ri < 3; ri++) begin
            for (int ci = 0; ci < 3; ci++) begin
                if (!((ci == 0 && w_left) || (ci == 2 && w_right) ||
                      (ri == 0 && w_top)  || (ri == 2 && w_bottom))) begin
                    w_window_masked[(ri*3+ci)*PIXEL_WIDTH +: PIXEL_WIDTH] = w_win_nx[ri][ci];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_col      <= '0;
            r_nx       <= '0;
            r_ny       <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_last   <= 1'b0;
            for (int ri = 0; ri < 3; ri++) begin
                for (int ci = 0; ci < 3; ci++) begin
                    r_win[ri][ci] <= '0;
                end
            end
        end else begin
            if (w_in_fire) begin
                r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
            end
            if (w_shift) begin
                r_win <= w_win_nx;
                r_col <= (r_col == c_X_MAX) ? '0 : r_col + 1'b1;
            end
            if (w_out_fire && out_last) begin
                r_col <= '0;
            end

            if (w_produce) begin
                out_valid  <= 1'b1;
                out_window <= w_window_masked;
                out_x      <= r_nx;
                out_y      <= r_ny;
                out_last   <= w_right && w_bottom;
                if (w_right) begin
                    r_nx <= '0;
                    r_ny <= w_bottom ? '0 : r_ny + 1'b1;
                end else begin
                    r_nx <= r_nx + 1'b1;
                end
            end else if (w_out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neighborhood_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_neighborhood_window_gen
// Brief    : Directed and table-driven bench for neighborhood_window_gen
//            with a 4x3 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neighborhood_window_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 16;
    localparam int N  = W * H;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            in_valid  = 1'b0;
    logic            in_ready;
    logic [PW-1:0]   in_pixel  = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [9*PW-1:0] out_window;
    logic [1:0]      out_x;
    logic [1:0]      out_y;
    logic            out_last;

    always #5 clk = ~clk;

    neighborhood_window_gen #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .PIXEL_WIDTH (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_last   (out_last)
    );

    typedef struct packed {
        logic [1:0]      x;
        logic [1:0]      y;
        logic            last;
        logic [9*PW-1:0] win;
    } rec_t;

    rec_t          tbl [N];
    rec_t          got_q [$];
    logic [PW-1:0] frm [2][N];
    int            errors = 0;
    int            checks = 0;
    rec_t          mon_cur;
    rec_t          mon_prev;
    bit            mon_stall = 1'b0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [9*PW-1:0] pk(input int t0, input int t1, input int t2,
                                           input int t3, input int t4, input int t5,
                                           input int t6, input int t7, input int t8);
        return {PW'(t8), PW'(t7), PW'(t6), PW'(t5), PW'(t4), PW'(t3), PW'(t2), PW'(t1), PW'(t0)};
    endfunction

    // Zero-padded neighbourhood straight from the stored frame.
    function automatic logic [9*PW-1:0] mdl(input int f, input int x, input int y);
        logic [9*PW-1:0] w;
        int xx, yy;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                xx = x + c - 1;
                yy = y + r - 1;
                if (xx >= 0 && xx < W && yy >= 0 && yy < H)
                    w[(r*3+c)*PW +: PW] = frm[f][yy*W+xx];
            end
        end
        return w;
    endfunction

    always @(negedge clk) begin
        mon_cur = {out_x, out_y, out_last, out_window};
        if (mon_stall && !rst)
            chk("hold_stable", 160'({out_valid, mon_cur}), 160'({1'b1, mon_prev}));
        if (out_valid && out_ready)
            got_q.push_back(mon_cur);
        mon_stall = out_valid && !out_ready;
        mon_prev  = mon_cur;
    end

    task automatic send(input logic [PW-1:0] v);
        bit hs;
        hs       = 1'b0;
        in_valid = 1'b1;
        in_pixel = v;
        for (int k = 0; k < 500 && !hs; k++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accept", 160'(hs), 160'(1));
    endtask

    task automatic wait_win(input int n);
        for (int k = 0; k < 3000 && got_q.size() < n; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("window_count", 160'(got_q.size()), 160'(n));
    endtask

    task automatic cmp_table(input string nm);
        rec_t g;
        for (int i = 0; i < N; i++) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            chk($sformatf("%s_win%0d", nm, i), 160'(g), 160'(tbl[i]));
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   done;
        int   nlast;
        rec_t e;

        tbl[0]  = {2'd0, 2'd0, 1'b0, pk(0, 0, 0,  0,  1,  2,  0,  5,  6)};
        tbl[1]  = {2'd1, 2'd0, 1'b0, pk(0, 0, 0,  1,  2,  3,  5,  6,  7)};
        tbl[2]  = {2'd2, 2'd0, 1'b0, pk(0, 0, 0,  2,  3,  4,  6,  7,  8)};
        tbl[3]  = {2'd3, 2'd0, 1'b0, pk(0, 0, 0,  3,  4,  0,  7,  8,  0)};
        tbl[4]  = {2'd0, 2'd1, 1'b0, pk(0, 1, 2,  0,  5,  6,  0,  9, 10)};
        tbl[5]  = {2'd1, 2'd1, 1'b0, pk(1, 2, 3,  5,  6,  7,  9, 10, 11)};
        tbl[6]  = {2'd2, 2'd1, 1'b0, pk(2, 3, 4,  6,  7,  8, 10, 11, 12)};
        tbl[7]  = {2'd3, 2'd1, 1'b0, pk(3, 4, 0,  7,  8,  0, 11, 12,  0)};
        tbl[8]  = {2'd0, 2'd2, 1'b0, pk(0, 5, 6,  0,  9, 10,  0,  0,  0)};
        tbl[9]  = {2'd1, 2'd2, 1'b0, pk(5, 6, 7,  9, 10, 11,  0,  0,  0)};
        tbl[10] = {2'd2, 2'd2, 1'b0, pk(6, 7, 8, 10, 11, 12,  0,  0,  0)};
        tbl[11] = {2'd3, 2'd2, 1'b1, pk(7, 8, 0, 11, 12,  0,  0,  0,  0)};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_in_ready", 160'(in_ready), 160'(0));
        chk("reset_outputs", 160'({out_valid, out_last, out_x, out_y, out_window}), 160'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("fill_in_ready", 160'(in_ready), 160'(1));
        @(posedge clk);
        #1;

        // Frame 1: free-running, first window latency, then flush
        got_q.delete();
        for (int i = 0; i < N; i++) begin
            if (i <= W + 1) chk("no_early_valid", 160'(out_valid), 160'(0));
            send(PW'(i + 1));
            if (i == W + 1) begin
                chk("first_win_valid", 160'(out_valid), 160'(1));
                chk("first_win", 160'({out_x, out_y, out_window}), 160'({2'd0, 2'd0, tbl[0].win}));
            end
        end
        in_valid = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            chk("flush_in_ready", 160'(in_ready), 160'(0));
            if (out_valid && out_last && out_ready) begin
                chk("flush_last_win", 160'({out_x, out_y, out_window}),
                    160'({2'd3, 2'd2, tbl[11].win}));
                @(posedge clk);
                #1;
                @(negedge clk);
                chk("ready_after_last", 160'(in_ready), 160'(1));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("flush_done", 160'(done), 160'(1));
        wait_win(N);
        cmp_table("free");

        // Backpressure after window (1,0)
        got_q.delete();
        fork
            begin
                for (int i = 0; i < N; i++) send(PW'(i + 1));
                in_valid = 1'b0;
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 200 && !seen; k++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid && out_x == 2'd1 && out_y == 2'd0) begin
                        seen      = 1'b1;
                        out_ready = 1'b0;
                    end
                end
                chk("bp_seen", 160'(seen), 160'(1));
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("bp_hold", 160'({out_valid, in_ready, out_x, out_y, out_window}),
                        160'({1'b1, 1'b0, 2'd1, 2'd0, tbl[1].win}));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_win(N);
        cmp_table("bp");

        // Back-to-back random frames with random gaps
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N; i++) frm[f][i] = PW'($urandom);
        got_q.delete();
        fork
            begin
                for (int f = 0; f < 2; f++) begin
                    for (int i = 0; i < N; i++) begin
                        in_valid = 1'b0;
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        send(frm[f][i]);
                    end
                end
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 3000 && got_q.size() < 2 * N; k++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_win(2 * N);
        nlast = 0;
        for (int i = 0; i < 2 * N; i++) begin
            int f, j;
            f = i / N;
            j = i % N;
            e = {2'(j % W), 2'(j / W), (j == N - 1), mdl(f, j % W, j / W)};
            if (i < got_q.size()) begin
                if (got_q[i].last) nlast++;
                chk($sformatf("b2b_win%0d", i), 160'(got_q[i]), 160'(e));
            end else begin
                chk($sformatf("b2b_win%0d", i), 160'(0), 160'(e));
            end
        end
        chk("b2b_last_count", 160'(nlast), 160'(2));

        // Reset mid-frame after 7 pixels
        for (int i = 0; i < 7; i++) send(PW'(i + 1));
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", 160'(in_ready), 160'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", 160'({out_valid, out_last, out_x, out_y, out_window}), 160'(0));
        chk("rst_mid_fill", 160'(in_ready), 160'(1));
        @(posedge clk);
        #1;
        got_q.delete();
        for (int i = 0; i < N; i++) send(PW'(i + 1));
        in_valid = 1'b0;
        wait_win(N);
        cmp_table("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
